// File: rtl/osc_pkg.sv
// Shared definitions for the oscilloscope acquisition stage: FSM states,
// horizontal zoom codes and the zoom-to-decimation lookup.
package osc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        READY     = 2'd3
    } osc_state_e;

    typedef enum logic [1:0] {
        ZOOM_X1     = 2'd0,
        ZOOM_X2     = 2'd1,
        ZOOM_X4     = 2'd2,
        ZOOM_X4_ALT = 2'd3
    } h_zoom_e;

    function automatic logic [2:0] decim_factor(input logic [1:0] zoom);
        logic [2:0] factor;
        case (h_zoom_e'(zoom))
            ZOOM_X1: factor = 3'd1;
            ZOOM_X2: factor = 3'd2;
            ZOOM_X4: factor = 3'd4;
            default: factor = 3'd4;
        endcase
        return factor;
    endfunction

endpackage

// File: rtl/osc_sample_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// The array itself carries no reset so it maps onto block RAM.
module osc_sample_ram
    import osc_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port, read-before-write on an address collision
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/osc_capture.sv
// Oscilloscope acquisition: ADC clock generation, decimation, edge/auto
// trigger and single-frame capture held until the display releases it.
module osc_capture
    import osc_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 10,
    parameter int CLK_DIV      = 2,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        h_zoom,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_falling,
    input  logic [DATA_W-1:0] ad_data_in,
    output logic              ad_clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_ready,
    output logic              triggered,
    input  logic              rd_done
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int TO_W  = $clog2(AUTO_TIMEOUT + 1);

    osc_state_e        state_r;
    logic [DIV_W-1:0]  div_cnt_r;
    logic [DIV_W-1:0]  div_nxt_s;
    logic              sample_stb_s;
    logic              ad_clk_r;
    logic [DATA_W-1:0] sample_r;
    logic              samp_vld_r;
    logic [1:0]        dec_cnt_r;
    logic [1:0]        dec_max_r;
    logic [1:0]        dec_nxt_s;
    logic [1:0]        dec_max_s;
    logic              dec_stb_s;
    logic [TO_W-1:0]   to_cnt_r;
    logic [DATA_W-1:0] prev_r;
    logic              prev_vld_r;
    logic              trig_hit_s;
    logic              timeout_s;
    logic              start_s;
    logic              we_s;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [ADDR_W-1:0] waddr_s;
    logic              frame_ready_r;
    logic              triggered_r;

    // Divider, decimation and trigger decode, write port steering
    always_comb begin
        div_nxt_s    = (div_cnt_r == DIV_W'(CLK_DIV - 1)) ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
        sample_stb_s = (div_cnt_r == DIV_W'(CLK_DIV - 1));
        dec_max_s    = 2'(decim_factor(h_zoom) - 3'd1);
        dec_nxt_s    = (dec_cnt_r == dec_max_r) ? 2'd0 : dec_cnt_r + 2'd1;
        dec_stb_s    = samp_vld_r && (dec_cnt_r == dec_max_r)
                       && ((state_r == WAIT_TRIG) || (state_r == CAPTURE));
        if (trig_falling) begin
            trig_hit_s = prev_vld_r && (prev_r >= trig_level) && (sample_r < trig_level);
        end else begin
            trig_hit_s = prev_vld_r && (prev_r < trig_level) && (sample_r >= trig_level);
        end
        timeout_s = (to_cnt_r == TO_W'(AUTO_TIMEOUT - 1));
        start_s   = enable && (state_r == WAIT_TRIG) && dec_stb_s && (trig_hit_s || timeout_s);
        we_s      = start_s || (enable && (state_r == CAPTURE) && dec_stb_s);
        waddr_s   = start_s ? {ADDR_W{1'b0}} : wr_addr_r + ADDR_W'(1);
    end

    // ADC clock divider and sample register; free-running regardless of enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_r  <= {DIV_W{1'b0}};
            ad_clk_r   <= 1'b0;
            sample_r   <= {DATA_W{1'b0}};
            samp_vld_r <= 1'b0;
        end else begin
            div_cnt_r  <= div_nxt_s;
            ad_clk_r   <= (div_nxt_s >= DIV_W'(CLK_DIV / 2));
            samp_vld_r <= sample_stb_s;
            if (sample_stb_s) begin
                sample_r <= ad_data_in;
            end
        end
    end

    // Acquisition FSM; every path into WAIT_TRIG clears counters and relatches D
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            frame_ready_r <= 1'b0;
            triggered_r   <= 1'b0;
            dec_cnt_r     <= 2'd0;
            dec_max_r     <= 2'd0;
            to_cnt_r      <= {TO_W{1'b0}};
            prev_r        <= {DATA_W{1'b0}};
            prev_vld_r    <= 1'b0;
            wr_addr_r     <= {ADDR_W{1'b0}};
        end else if (!enable) begin
            state_r       <= IDLE;
            frame_ready_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    frame_ready_r <= 1'b0;
                    state_r       <= WAIT_TRIG;
                    dec_cnt_r     <= 2'd0;
                    dec_max_r     <= dec_max_s;
                    to_cnt_r      <= {TO_W{1'b0}};
                    prev_vld_r    <= 1'b0;
                end
                WAIT_TRIG: begin
                    if (samp_vld_r) begin
                        dec_cnt_r <= dec_nxt_s;
                    end
                    if (start_s) begin
                        triggered_r <= trig_hit_s;
                        wr_addr_r   <= {ADDR_W{1'b0}};
                        state_r     <= CAPTURE;
                    end else if (dec_stb_s) begin
                        to_cnt_r   <= to_cnt_r + TO_W'(1);
                        prev_r     <= sample_r;
                        prev_vld_r <= 1'b1;
                    end
                end
                CAPTURE: begin
                    if (samp_vld_r) begin
                        dec_cnt_r <= dec_nxt_s;
                    end
                    if (dec_stb_s) begin
                        wr_addr_r <= waddr_s;
                        if (waddr_s == {ADDR_W{1'b1}}) begin
                            state_r       <= READY;
                            frame_ready_r <= 1'b1;
                        end
                    end
                end
                READY: begin
                    if (rd_done) begin
                        frame_ready_r <= 1'b0;
                        state_r       <= WAIT_TRIG;
                        dec_cnt_r     <= 2'd0;
                        dec_max_r     <= dec_max_s;
                        to_cnt_r      <= {TO_W{1'b0}};
                        prev_vld_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r       <= IDLE;
                    frame_ready_r <= 1'b0;
                end
            endcase
        end
    end

    osc_sample_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (sample_r),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign ad_clk      = ad_clk_r;
    assign frame_ready = frame_ready_r;
    assign triggered   = triggered_r;

endmodule

// File: tb/tb_osc_capture.sv
// Directed self-checking bench for osc_capture (CLK_DIV=2, AUTO_TIMEOUT=16).
module tb_osc_capture;
    import osc_pkg::*;

    logic       clk, reset, enable, trig_falling, ad_clk, frame_ready, triggered, rd_done;
    logic [1:0] h_zoom;
    logic [7:0] trig_level, ad_data_in, rd_data;
    logic [9:0] rd_addr;

    int checks = 0;
    int errors = 0;

    logic       gen_on = 1'b0;
    logic [7:0] gen_val = 8'h00;
    logic [7:0] gen_step = 8'h01;

    osc_capture #(
        .DATA_W(8), .ADDR_W(10), .CLK_DIV(2), .AUTO_TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .h_zoom(h_zoom),
        .trig_level(trig_level), .trig_falling(trig_falling),
        .ad_data_in(ad_data_in), .ad_clk(ad_clk), .rd_addr(rd_addr),
        .rd_data(rd_data), .frame_ready(frame_ready), .triggered(triggered),
        .rd_done(rd_done)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // One clock step; the ramp advances once per ADC sample period
    task automatic tick();
        @(negedge clk);
        if (gen_on && ad_clk) begin
            ad_data_in = gen_val;
            gen_val    = gen_val + gen_step;
        end
    endtask

    task automatic read_mem(input logic [9:0] a, output logic [7:0] d);
        tick();
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    task automatic wait_ready(input int lim, output int n);
        n = 0;
        while (frame_ready !== 1'b1 && n < lim) begin
            tick();
            n++;
        end
    endtask

    task automatic arm_ramp(input logic [1:0] zoom, input logic falling,
                            input logic [7:0] static_v, input logic [7:0] start_v,
                            input logic [7:0] step);
        enable = 1'b0;
        gen_on = 1'b0;
        ad_data_in = static_v;
        trig_level = 8'h80;
        h_zoom = zoom;
        trig_falling = falling;
        repeat (10) tick();
        enable = 1'b1;
        repeat (4) tick();
        gen_val = start_v;
        gen_step = step;
        gen_on = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] pat;
        pat = 4'b0000;
        repeat (3) tick();
        checks++; if (ad_clk !== 1'b0) begin errors++; $display("FAIL rst_ad_clk got %b want 0", ad_clk); end
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL rst_frame_ready got %b want 0", frame_ready); end
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL rst_triggered got %b want 0", triggered); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h want 00", rd_data); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pat = {pat[2:0], ad_clk};
        end
        checks++; if (pat !== 4'b1010) begin errors++; $display("FAIL ad_clk_pattern got %b want 1010", pat); end
        // Start a rising capture, then reset in the middle of it
        rd_addr = 10'd0;
        arm_ramp(2'd0, 1'b0, 8'h78, 8'h79, 8'h01);
        repeat (600) tick();
        checks++; if (rd_data !== 8'h80) begin errors++; $display("FAIL read_during_capture got %h want 80", rd_data); end
        checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL mid_capture_triggered got %b want 1", triggered); end
        gen_on = 1'b0;
        reset = 1'b1;
        #1;
        checks++; if (ad_clk !== 1'b0) begin errors++; $display("FAIL midrst_ad_clk got %b want 0", ad_clk); end
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL midrst_frame_ready got %b want 0", frame_ready); end
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL midrst_triggered got %b want 0", triggered); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL midrst_rd_data got %h want 00", rd_data); end
        checks++; if (dut.state_r !== IDLE) begin errors++; $display("FAIL midrst_state got %0d want IDLE", dut.state_r); end
        tick();
        reset = 1'b0;
        repeat (2) tick();
        checks++; if (dut.state_r !== WAIT_TRIG) begin errors++; $display("FAIL post_rst_state got %0d want WAIT_TRIG", dut.state_r); end
    endtask

    task automatic test_rising();
        int n;
        logic [7:0] d;
        arm_ramp(2'd0, 1'b0, 8'h78, 8'h79, 8'h01);
        wait_ready(3000, n);
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL rise_ready got %b want 1 after %0d cycles", frame_ready, n); end
        checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL rise_triggered got %b want 1", triggered); end
        read_mem(10'd0, d);
        checks++; if (d !== 8'h80) begin errors++; $display("FAIL rise_mem0 got %h want 80", d); end
        read_mem(10'd1, d);
        checks++; if (d !== 8'h81) begin errors++; $display("FAIL rise_mem1 got %h want 81", d); end
        read_mem(10'd100, d);
        checks++; if (d !== 8'hE4) begin errors++; $display("FAIL rise_mem100 got %h want e4", d); end
        read_mem(10'd1023, d);
        checks++; if (d !== 8'h7F) begin errors++; $display("FAIL rise_mem1023 got %h want 7f", d); end
    endtask

    task automatic test_falling_decim();
        int n;
        logic [7:0] d0, d;
        arm_ramp(2'd2, 1'b1, 8'h88, 8'h87, 8'hFF);
        wait_ready(10000, n);
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL fall_ready got %b want 1 after %0d cycles", frame_ready, n); end
        checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL fall_triggered got %b want 1", triggered); end
        read_mem(10'd0, d0);
        checks++; if (d0 > 8'h7F || d0 < 8'h7C) begin errors++; $display("FAIL fall_mem0 got %h want 7c..7f", d0); end
        read_mem(10'd1, d);
        checks++; if (d !== 8'(d0 - 8'd4)) begin errors++; $display("FAIL fall_mem1 got %h want %h", d, 8'(d0 - 8'd4)); end
        read_mem(10'd1023, d);
        checks++; if (d !== 8'(d0 + 8'd4)) begin errors++; $display("FAIL fall_mem1023 got %h want %h", d, 8'(d0 + 8'd4)); end
    endtask

    task automatic test_auto();
        int n;
        logic [7:0] d;
        enable = 1'b0;
        gen_on = 1'b0;
        ad_data_in = 8'h40;
        trig_level = 8'h80;
        h_zoom = 2'd0;
        trig_falling = 1'b0;
        repeat (10) tick();
        enable = 1'b1;
        wait_ready(3000, n);
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL auto_ready got %b want 1", frame_ready); end
        checks++; if (n < 2078 || n > 2079) begin errors++; $display("FAIL auto_latency got %0d want 2078..2079", n); end
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL auto_triggered got %b want 0", triggered); end
        read_mem(10'd0, d);
        checks++; if (d !== 8'h40) begin errors++; $display("FAIL auto_mem0 got %h want 40", d); end
        read_mem(10'd511, d);
        checks++; if (d !== 8'h40) begin errors++; $display("FAIL auto_mem511 got %h want 40", d); end
        read_mem(10'd1023, d);
        checks++; if (d !== 8'h40) begin errors++; $display("FAIL auto_mem1023 got %h want 40", d); end
    endtask

    task automatic test_hold_rearm();
        int n;
        logic [7:0] d;
        ad_data_in = 8'h78;
        repeat (50) tick();
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL hold_ready got %b want 1", frame_ready); end
        read_mem(10'd5, d);
        checks++; if (d !== 8'h40) begin errors++; $display("FAIL hold_mem5 got %h want 40", d); end
        tick();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL rearm_ready_clear got %b want 0", frame_ready); end
        gen_val = 8'h79;
        gen_step = 8'h01;
        gen_on = 1'b1;
        n = 0;
        while (frame_ready !== 1'b1 && n < 3000) begin
            rd_done = (n == 300);
            tick();
            n++;
        end
        rd_done = 1'b0;
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL rearm_ready got %b want 1", frame_ready); end
        checks++; if (n < 2040 || n > 2150) begin errors++; $display("FAIL rearm_latency got %0d want 2040..2150", n); end
        checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL rearm_triggered got %b want 1", triggered); end
        read_mem(10'd0, d);
        checks++; if (d !== 8'h80) begin errors++; $display("FAIL rearm_mem0 got %h want 80", d); end
    endtask

    task automatic test_enable_drop();
        int n;
        logic [7:0] d;
        arm_ramp(2'd0, 1'b0, 8'h78, 8'h79, 8'h01);
        repeat (1000) tick();
        checks++; if (dut.state_r !== CAPTURE) begin errors++; $display("FAIL drop_pre_state got %0d want CAPTURE", dut.state_r); end
        enable = 1'b0;
        tick();
        checks++; if (dut.state_r !== IDLE) begin errors++; $display("FAIL drop_state got %0d want IDLE", dut.state_r); end
        repeat (1500) tick();
        checks++; if (frame_ready !== 1'b0) begin errors++; $display("FAIL drop_ready got %b want 0", frame_ready); end
        arm_ramp(2'd0, 1'b0, 8'h78, 8'h79, 8'h01);
        wait_ready(3000, n);
        checks++; if (frame_ready !== 1'b1) begin errors++; $display("FAIL reen_ready got %b want 1", frame_ready); end
        read_mem(10'd0, d);
        checks++; if (d !== 8'h80) begin errors++; $display("FAIL reen_mem0 got %h want 80", d); end
        read_mem(10'd1023, d);
        checks++; if (d !== 8'h7F) begin errors++; $display("FAIL reen_mem1023 got %h want 7f", d); end
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b0;
        h_zoom = 2'd0;
        trig_level = 8'h80;
        trig_falling = 1'b0;
        ad_data_in = 8'h00;
        rd_addr = 10'd0;
        rd_done = 1'b0;
        test_reset();
        test_rising();
        test_falling_decim();
        test_auto();
        test_hold_rearm();
        test_enable_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/osc_capture.md
Name: osc_capture

Overview:
- Oscilloscope acquisition stage that sits directly upstream of the HDMI display block in OSI mode.
- Generates the ADC sample clock, samples ad_data_in, and decimates per the horizontal zoom setting.
- Detects an edge trigger (or auto-timeout), fills a DEPTH-sample frame buffer, then holds the frame until the display side releases it.

Parameters:
- DATA_W, 8, ADC sample width
- ADDR_W, 10, frame buffer address width; DEPTH = 2**ADDR_W
- CLK_DIV, 2, clk cycles per ADC sample, even and >= 2
- AUTO_TIMEOUT, 65535, decimated samples to wait for a trigger before forcing capture

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  acquisition enable, driven from OSI-mode confirm; low forces IDLE
- h_zoom  in  2  decimation select: 0 -> 1, 1 -> 2, 2 -> 4, 3 treated as 4
- trig_level  in  DATA_W  trigger threshold, unsigned
- trig_falling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger
- ad_data_in  in  DATA_W  ADC sample bus
- ad_clk  out  1  ADC clock
- rd_addr  in  ADDR_W  display read address
- rd_data  out  DATA_W  frame sample at rd_addr, 1-cycle latency
- frame_ready  out  1  a full frame is held and readable
- triggered  out  1  last frame started on a real trigger (0 = auto)
- rd_done  in  1  one-cycle pulse from display: frame consumed, re-arm

Behaviour:
- Reset values: ad_clk=0, rd_data=0, frame_ready=0, triggered=0, state=IDLE, all counters 0.
- Sample clock:
  - Divider counts 0..CLK_DIV-1 whenever reset is low, independent of enable.
  - ad_clk=1 for counts >= CLK_DIV/2.
  - sample_stb asserts on count CLK_DIV-1; ad_data_in is registered on that cycle.
- Decimation:
  - Decimation factor D is latched from h_zoom on entry to WAIT_TRIG.
  - A decimated strobe fires on every D-th sample_stb; the decimation counter clears on entry to WAIT_TRIG.
- Trigger uses decimated samples only, with prev = previous decimated sample:
  - rising: prev < trig_level && cur >= trig_level
  - falling: prev >= trig_level && cur < trig_level
  - prev is invalid for the first decimated sample after WAIT_TRIG entry, so no trigger can fire on it.
- State machine:
  - IDLE: frame_ready=0. Go to WAIT_TRIG when enable=1.
  - WAIT_TRIG: timeout counter increments per decimated strobe.
    - On a trigger: write the triggering sample to addr 0, set triggered=1, go to CAPTURE.
    - On timeout reaching AUTO_TIMEOUT: write the current sample to addr 0, set triggered=0, go to CAPTURE.
    - Trigger wins if both occur on the same strobe.
  - CAPTURE: write each decimated sample at wr_addr+1. After the write to DEPTH-1, go to READY on the next cycle (exactly DEPTH samples per frame).
  - READY: frame_ready=1, no writes, buffer frozen. rd_done=1 clears frame_ready the next cycle and goes to WAIT_TRIG (counters cleared, D relatched).
- rd_done outside READY is ignored.
- enable=0 in any state: go to IDLE next cycle and clear frame_ready. Partial frame contents are undefined; triggered holds its value.
- Read port:
  - rd_data <= mem[rd_addr] every clk, regardless of state.
  - Reading while a capture is in progress returns whatever is currently stored (no collision guard; the display gates reads with frame_ready).
- Asynchronous reset mid-capture returns to IDLE immediately. RAM contents are not cleared.

Decomposition:
- Shared package osc_pkg holds:
  - state encoding IDLE / WAIT_TRIG / CAPTURE / READY
  - h_zoom codes and the decimation lookup (0->1, 1->2, 2->4, 3->4)
- One sub-module: osc_sample_ram, a simple dual-port RAM (write port plus registered read port, DEPTH x DATA_W) so it infers block RAM.

Test Plan:
- Reset: assert reset mid-capture -> ad_clk=0, frame_ready=0, triggered=0, rd_data=0; after release with enable=1, FSM is in WAIT_TRIG.
- Rising trigger: CLK_DIV=2, h_zoom=0, trig_level=0x80, ramp input 0x00..0xFF step 1 -> frame_ready after 1024 samples; mem[0]=0x80, mem[1]=0x81, triggered=1.
- Falling trigger and decimation: trig_falling=1, h_zoom=2, descending ramp step 1 -> mem[0] is the first value < trig_level; consecutive entries differ by 4.
- Auto mode: constant input 0x40, trig_level=0x80, AUTO_TIMEOUT=16 -> capture starts after 16 decimated samples; frame_ready=1, triggered=0, all entries 0x40.
- Hold and re-arm: with frame_ready=1, change the input -> buffer unchanged; rd_done pulse -> frame_ready=0 next cycle, and a new frame arrives on the next trigger. rd_done pulsed during CAPTURE -> no effect.
- Enable drop: deassert enable halfway through CAPTURE -> IDLE, frame_ready stays 0. Re-enable -> full capture completes normally.
